onchip_rr_arbiter: RTL and testbench



---
 rtl/onchip_arb_pkg.sv | 22 ++
 rtl/onchip_rr_arbiter_if.sv | 66 ++++++
 rtl/onchip_rr_pick.sv | 23 ++
 rtl/onchip_rr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_onchip_rr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_arb_pkg.sv
// Shared types and constants for the on-chip RAM round-robin arbiter.
// The optional lock feature is enabled with ONCHIP_ARB_LOCK_EN.
package onchip_arb_pkg;

  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 32;
  localparam int LOCK_TIMEOUT = 16;
  localparam int LOCK_CNT_W   = 4;

  // Index of one of the two requesters.
  typedef logic mst_idx_t;
  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

  // Bus-lock ownership state (only used when ONCHIP_ARB_LOCK_EN is defined).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } lock_state_t;

endpackage

// File: rtl/onchip_rr_arbiter_if.sv
// Avalon-MM master-side bundle and RAM-side bundle used by onchip_rr_arbiter.
// The lock signal exists only when ONCHIP_ARB_LOCK_EN is defined.
interface onchip_avmm_if
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
`ifdef ONCHIP_ARB_LOCK_EN
  logic              lock;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
`else
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
`endif
endinterface

interface onchip_mem_if
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );
  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/onchip_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins, on
// contention the master that was not granted last wins.
module onchip_rr_pick
  import onchip_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last_gnt,
  output logic [1:0] gnt
);

  // One-hot grant from request vector and previous winner.
  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves it unassigned (latch).
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == MST1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/onchip_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM
// (registered address, unregistered q: one-cycle read latency).
// Optional bus lock: define ONCHIP_ARB_LOCK_EN.
module onchip_rr_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          reset_n,
  onchip_avmm_if.slave m0,
  onchip_avmm_if.slave m1,
  onchip_mem_if.master mem
);

  localparam int BE_W = DATA_W / 8;

  logic [1:0]        req_raw;
  logic [1:0]        allow;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              any_gnt;
  mst_idx_t          win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [BE_W-1:0]   win_be;
  logic [DATA_W-1:0] win_wdata;
  logic              win_read;
  logic              win_write;
  logic              win_rd;

  mst_idx_t          last_gnt_q, last_gnt_d;
  logic              rd_pend_q, rd_pend_d;
  mst_idx_t          rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Read and write together count as a single request (handled as a write).
  assign req_raw = {m1.read | m1.write, m0.read | m0.write};
  // Nobody is granted while reset is held.
  assign req     = req_raw & allow & {2{reset_n}};

  onchip_rr_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  assign any_gnt = |gnt;
  assign win_idx = gnt[1] ? MST1 : MST0;

  // Select the winning master's command fields.
  always_comb begin
    win_addr  = m0.address;
    win_be    = m0.byteenable;
    win_wdata = m0.writedata;
    win_read  = m0.read;
    win_write = m0.write;
    if (win_idx == MST1) begin
      win_addr  = m1.address;
      win_be    = m1.byteenable;
      win_wdata = m1.writedata;
      win_read  = m1.read;
      win_write = m1.write;
    end
  end

  assign win_rd = any_gnt & win_read & ~win_write;

`ifdef ONCHIP_ARB_LOCK_EN
  lock_state_t           lk_state_q, lk_state_d;
  logic [LOCK_CNT_W-1:0] lk_cnt_q, lk_cnt_d;
  logic                  win_lock;
  mst_idx_t              lk_owner;

  assign win_lock = (win_idx == MST1) ? m1.lock : m0.lock;
  assign lk_owner = (lk_state_q == OWN1) ? MST1 : MST0;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lk_state_q <= IDLE;
      lk_cnt_q   <= '0;
    end else begin
      lk_state_q <= lk_state_d;
      lk_cnt_q   <= lk_cnt_d;
    end
  end

  // Lock next state: enter on a locked grant, leave on an unlocked owner
  // access or after the owner stays idle for LOCK_TIMEOUT cycles.
  always_comb begin
    lk_state_d = lk_state_q;
    lk_cnt_d   = lk_cnt_q;
    case (lk_state_q)
      IDLE: begin
        lk_cnt_d = '0;
        if (any_gnt && win_lock) begin
          lk_state_d = (win_idx == MST1) ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (gnt[lk_owner]) begin
          lk_cnt_d = '0;
          if (!win_lock) begin
            lk_state_d = IDLE;
          end
        end else if (!req_raw[lk_owner]) begin
          if (lk_cnt_q == LOCK_CNT_W'(LOCK_TIMEOUT - 1)) begin
            lk_state_d = IDLE;
            lk_cnt_d   = '0;
          end else begin
            lk_cnt_d = lk_cnt_q + 1'b1;
          end
        end else begin
          lk_cnt_d = '0;
        end
      end
      default: begin
        lk_state_d = IDLE;
        lk_cnt_d   = '0;
      end
    endcase
  end

  // Lock output: while a master owns the bus only it may be granted.
  always_comb begin
    allow = 2'b11;
    case (lk_state_q)
      OWN0:    allow = 2'b01;
      OWN1:    allow = 2'b10;
      default: allow = 2'b11;
    endcase
  end
`else
  assign allow = 2'b11;
`endif

  // Next-state for the round-robin pointer, read tracking and held RAM fields.
  always_comb begin
    last_gnt_d = last_gnt_q;
    rd_pend_d  = win_rd;
    rd_owner_d = rd_owner_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    if (any_gnt) begin
      last_gnt_d = win_idx;
      addr_d     = win_addr;
      be_d       = win_be;
      wdata_d    = win_wdata;
    end
    if (win_rd) begin
      rd_owner_d = win_idx;
    end
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset_n) begin
      last_gnt_q <= MST1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= MST0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
    end
  end

  assign m0.waitrequest   = ~gnt[0];
  assign m1.waitrequest   = ~gnt[1];
  assign m0.readdata      = mem.readdata;
  assign m1.readdata      = mem.readdata;
  // Gating with reset_n drops a read that was in flight when reset asserted.
  assign m0.readdatavalid = reset_n & rd_pend_q & (rd_owner_q == MST0);
  assign m1.readdatavalid = reset_n & rd_pend_q & (rd_owner_q == MST1);

  assign mem.address    = any_gnt ? win_addr  : addr_q;
  assign mem.byteenable = any_gnt ? win_be    : be_q;
  assign mem.writedata  = any_gnt ? win_wdata : wdata_q;
  assign mem.chipselect = any_gnt;
  assign mem.write      = any_gnt & win_write;
  assign mem.clken      = reset_n;

endmodule

// File: tb/tb_onchip_rr_arbiter.sv
// Self-checking bench for onchip_rr_arbiter with a behavioural RAM
// (registered address, unregistered q). Lock scenario runs when
// ONCHIP_ARB_LOCK_EN is defined.
module tb_onchip_rr_arbiter;
  import onchip_arb_pkg::*;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } rd_exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  onchip_avmm_if m0_if ();
  onchip_avmm_if m1_if ();
  onchip_mem_if  mem_if ();

  onchip_rr_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .mem     (mem_if)
  );

  // Behavioural RAM: write and address capture on clken, q follows the registered address.
  logic [31:0] ram [1024];
  logic [9:0]  ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_if.clken) begin
      if (mem_if.chipselect && mem_if.write) begin
        for (int b = 0; b < 4; b++)
          if (mem_if.byteenable[b]) ram[mem_if.address][8*b +: 8] <= mem_if.writedata[8*b +: 8];
      end
      ram_addr_q <= mem_if.address;
    end
  end
  assign mem_if.readdata = ram[ram_addr_q];

  int          checks   = 0;
  int          failures = 0;
  rd_exp_t     exp_q[$];
  logic [31:0] ref_mem [1024];
  int          last_m;
  logic [9:0]  last_addr;
  logic        have_last;
  logic [31:0] last_rd_data;
  logic        wait0_s, wait1_s;
  int          own;
  int          idle_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic rd, input logic wr, input logic [9:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = d;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = d;
    end
  endtask

  // One clock cycle: check outputs against the reference model at negedge, then advance.
  task automatic tick();
    rd_exp_t     e;
    logic        have;
    logic [1:0]  rq_raw, rq;
    int          win;
    logic        w_rd, w_wr, w_lock;
    logic [9:0]  w_a;
    logic [3:0]  w_be;
    logic [31:0] w_d;
    @(negedge clk);
    have = 1'b0;
    e.idx = -1; e.data = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      have = reset_n;
    end
    check("rdv0", m0_if.readdatavalid, have && e.idx == 0);
    check("rdv1", m1_if.readdatavalid, have && e.idx == 1);
    if (have) check("rdata", (e.idx == 1) ? m1_if.readdata : m0_if.readdata, e.data);
    if (m0_if.readdatavalid) last_rd_data = m0_if.readdata;
    if (m1_if.readdatavalid) last_rd_data = m1_if.readdata;

    rq_raw = reset_n ? {m1_if.read | m1_if.write, m0_if.read | m0_if.write} : 2'b00;
    rq = rq_raw;
    if (own == 0) rq[1] = 1'b0;
    if (own == 1) rq[0] = 1'b0;
    win = -1;
    if (rq == 2'b11)  win = (last_m == 1) ? 0 : 1;
    else if (rq[0])   win = 0;
    else if (rq[1])   win = 1;

    wait0_s = m0_if.waitrequest;
    wait1_s = m1_if.waitrequest;
    check("wait0", m0_if.waitrequest, win != 0);
    check("wait1", m1_if.waitrequest, win != 1);
    check("chipselect", mem_if.chipselect, win >= 0);
    check("clken", mem_if.clken, reset_n);

    w_lock = 1'b0;
    if (win >= 0) begin
      w_rd = (win == 1) ? m1_if.read       : m0_if.read;
      w_wr = (win == 1) ? m1_if.write      : m0_if.write;
      w_a  = (win == 1) ? m1_if.address    : m0_if.address;
      w_be = (win == 1) ? m1_if.byteenable : m0_if.byteenable;
      w_d  = (win == 1) ? m1_if.writedata  : m0_if.writedata;
`ifdef ONCHIP_ARB_LOCK_EN
      w_lock = (win == 1) ? m1_if.lock : m0_if.lock;
`endif
      check("mem_address", mem_if.address, w_a);
      check("mem_write", mem_if.write, w_wr);
      if (w_wr) begin
        check("mem_be", mem_if.byteenable, w_be);
        check("mem_wdata", mem_if.writedata, w_d);
        for (int b = 0; b < 4; b++)
          if (w_be[b]) ref_mem[w_a][8*b +: 8] = w_d[8*b +: 8];
      end else if (w_rd) begin
        exp_q.push_back('{idx: win, data: ref_mem[w_a]});
      end
      last_addr = w_a;
      have_last = 1'b1;
    end else if (reset_n && have_last) begin
      check("addr_hold", mem_if.address, last_addr);
    end

    @(posedge clk);
    #1;
    if (!reset_n) begin
      last_m = 1; exp_q.delete(); have_last = 1'b0; own = -1; idle_cnt = 0;
    end else begin
      if (win >= 0) last_m = win;
      if (own < 0) begin
        if (win >= 0 && w_lock) begin own = win; idle_cnt = 0; end
      end else if (win == own) begin
        idle_cnt = 0;
        if (!w_lock) own = -1;
      end else if (!rq_raw[own]) begin
        if (idle_cnt == LOCK_TIMEOUT - 1) begin own = -1; idle_cnt = 0; end
        else idle_cnt++;
      end else begin
        idle_cnt = 0;
      end
    end
  endtask

  task automatic idle_both();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_both();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    last_m = 1; own = -1; idle_cnt = 0; have_last = 1'b0; last_rd_data = '0;
`ifdef ONCHIP_ARB_LOCK_EN
    m0_if.lock = 1'b0;
    m1_if.lock = 1'b0;
`endif
    @(posedge clk); #1;
    do_reset();
    tick();

    // m0 write then m1 read of the same word.
    drive(0, 0, 1, 10'h005, 4'hF, 32'hDEADBEEF);
    tick();
    check("m0_write_accepted", wait0_s, 1'b0);
    idle_both();
    drive(1, 1, 0, 10'h005, 4'hF, '0);
    tick();
    idle_both();
    tick();
    check("m1_read_deadbeef", last_rd_data, 32'hDEADBEEF);

    // Both masters reading continuously straight out of reset.
    do_reset();
    drive(0, 1, 0, 10'h005, 4'hF, '0);
    drive(1, 1, 0, 10'h006, 4'hF, '0);
    tick();
    check("first_contention_m0", wait0_s, 1'b0);
    tick();
    check("second_grant_m1", wait1_s, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 10'(i + 1), 4'hF, '0);
      drive(1, 1, 0, 10'(i + 2), 4'hF, '0);
      tick();
    end
    idle_both();
    tick();

    // Byte-lane masking at the top address.
    drive(1, 0, 1, 10'h3FF, 4'hF, 32'hFFFFFFFF);
    tick();
    drive(1, 0, 1, 10'h3FF, 4'h2, 32'h0000AB00);
    tick();
    drive(1, 1, 0, 10'h3FF, 4'hF, '0);
    tick();
    idle_both();
    tick();
    check("byte_mask_3ff", last_rd_data, 32'hFFFFABFF);

    // Reset while a read is in flight: no return, m0 wins afterwards.
    drive(0, 1, 0, 10'h005, 4'hF, '0);
    tick();
    reset_n = 1'b0;
    idle_both();
    tick();
    reset_n = 1'b1;
    drive(0, 1, 0, 10'h005, 4'hF, '0);
    drive(1, 1, 0, 10'h006, 4'hF, '0);
    tick();
    check("post_reset_m0_wins", wait0_s, 1'b0);
    idle_both();
    tick();

    // Read+write together is a write with no data return.
    drive(0, 1, 1, 10'h010, 4'hF, 32'h12345678);
    tick();
    idle_both();
    tick();
    drive(0, 1, 0, 10'h010, 4'hF, '0);
    tick();
    idle_both();
    tick();
    check("rw_as_write", last_rd_data, 32'h12345678);

    // Write then read of the same word by different masters in consecutive cycles.
    drive(0, 0, 1, 10'h020, 4'hF, 32'hCAFEF00D);
    tick();
    idle_both();
    drive(1, 1, 0, 10'h020, 4'hF, '0);
    tick();
    idle_both();
    tick();
    check("read_after_write", last_rd_data, 32'hCAFEF00D);

`ifdef ONCHIP_ARB_LOCK_EN
    // m0 locks the bus for three writes, then idles until the timeout releases it.
    do_reset();
    drive(1, 1, 0, 10'h005, 4'hF, '0);
    m0_if.lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 10'(10'h030 + i), 4'hF, 32'(i + 32'h100));
      tick();
      check("lock_m1_waits", wait1_s, 1'b1);
    end
    drive(0, 0, 0, '0, '0, '0);
    for (int i = 0; i < LOCK_TIMEOUT; i++) begin
      tick();
      check("lock_idle_m1_waits", wait1_s, 1'b1);
    end
    tick();
    check("lock_timeout_m1_granted", wait1_s, 1'b0);
    m0_if.lock = 1'b0;
    idle_both();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
